// File: rtl/z80_mem_pkg.sv
// z80_mem_pkg: shared FSM state encodings and default IO port constants
package z80_mem_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [7:0] DEF_SHADOW_PORT = 8'h7F;
    localparam logic [7:0] DEF_PAGE_PORT = 8'h7E;
    localparam int DEF_PAGE_RST = 3;
endpackage

// File: rtl/z80_memctl_if.sv
// z80_memctl_if: Z80 CPU bus between the core (master) and the memory controller (slave)
interface z80_memctl_if;
    logic [15:0] cpu_a;
    logic [7:0] cpu_do;
    logic [7:0] cpu_di;
    logic cpu_mreq;
    logic cpu_iorq;
    logic cpu_wr;
    logic cpu_m1;
    logic cpu_wait;
    modport master (output cpu_a, cpu_do, cpu_mreq, cpu_iorq, cpu_wr, cpu_m1, input cpu_di, cpu_wait);
    modport slave (input cpu_a, cpu_do, cpu_mreq, cpu_iorq, cpu_wr, cpu_m1, output cpu_di, cpu_wait);
endinterface

// File: rtl/z80_waitgen.sv
// z80_waitgen: inserts exactly FLASH_WS wait cycles at the start of each Flash read
module z80_waitgen
    import z80_mem_pkg::*;
#(
    parameter int FLASH_WS = 2
) (
    input  logic zclk,
    input  logic reset_n,
    input  logic hold,
    input  logic req,
    output logic wait_o
);
    localparam logic [3:0] WS = 4'(FLASH_WS);
    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d, cnt_m;
    always_comb begin
        cnt_m = cnt_q - 4'd1;
        state_d = state_q;
        cnt_d = cnt_q;
        if (hold || !req || WS == 4'd0) begin
            state_d = ST_IDLE;
            cnt_d = 4'd0;
        end else if (state_q == ST_IDLE) begin
            // the IDLE cycle itself is the first wait, so a single wait skips WAIT
            state_d = WS == 4'd1 ? ST_DONE : ST_WAIT;
            cnt_d = WS - 4'd1;
        end else if (state_q == ST_WAIT) begin
            state_d = cnt_m == 4'd0 ? ST_DONE : ST_WAIT;
            cnt_d = cnt_m;
        end else begin
            state_d = ST_DONE;
        end
        wait_o = req && !hold && WS != 4'd0 && (state_q == ST_IDLE || state_q == ST_WAIT);
    end
    always_ff @(posedge zclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/z80_memctl.sv
// z80_memctl: Z80 memory/IO decoder with Flash shadowing, window-3 paging, wait states and reset stretch
module z80_memctl
    import z80_mem_pkg::*;
#(
    parameter int FLASH_WS = 2,
    parameter int RST_W = 21,
    parameter int PAGE_W = 4,
    parameter int SHADOW_MODE = 0,
    parameter logic [7:0] SHADOW_PORT = DEF_SHADOW_PORT,
    parameter logic [7:0] PAGE_PORT = DEF_PAGE_PORT
) (
    input  logic zclk,
    input  logic reset_n,
    z80_memctl_if.slave bus,
    output logic cpu_reset,
    output logic romreq,
    output logic ramreq,
    output logic ramwr,
    output logic [PAGE_W+13:0] ma,
    input  logic [7:0] fdata,
    input  logic [15:0] sdata
);
    localparam logic [RST_W-1:0] RST_LAST = ~RST_W'(1);
    logic [1:0] win;
    logic io_wr, io_rd, hit_page;
    logic [PAGE_W-1:0] page;
    logic [RST_W-1:0] rcnt_q, rcnt_d;
    logic rdone_q, rdone_d;
    logic shadow_q, shadow_d;
    logic [PAGE_W-1:0] page_q, page_d;
    logic wait_w;
    always_comb begin
        win = bus.cpu_a[15:14];
        io_wr = bus.cpu_iorq & bus.cpu_wr & !bus.cpu_m1;
        io_rd = bus.cpu_iorq & !bus.cpu_wr & !bus.cpu_m1;
        hit_page = bus.cpu_a[7:0] == PAGE_PORT;
        romreq = bus.cpu_mreq & !bus.cpu_wr & (win == 2'd0) & !shadow_q;
        ramreq = bus.cpu_mreq & (shadow_q | bus.cpu_wr | (win != 2'd0));
        // shadowed window 0 is RAM that the CPU may read but not overwrite
        ramwr = bus.cpu_mreq & bus.cpu_wr & (!shadow_q | (win != 2'd0));
        page = (win == 2'd3) ? page_q : PAGE_W'(win);
        ma = {page, bus.cpu_a[13:0]};
        bus.cpu_di = romreq ? fdata :
                     bus.cpu_mreq ? (bus.cpu_a[0] ? sdata[15:8] : sdata[7:0]) :
                     (io_rd & hit_page) ? ({shadow_q, 7'd0} | 8'(page_q)) : 8'hFF;
        bus.cpu_wait = wait_w;
        page_d = (io_wr & hit_page) ? bus.cpu_do[PAGE_W-1:0] : page_q;
        shadow_d = (SHADOW_MODE == 0) ? (shadow_q | (bus.cpu_iorq & !bus.cpu_m1)) :
                   (io_wr & (bus.cpu_a[7:0] == SHADOW_PORT)) ? bus.cpu_do[0] : shadow_q;
        rdone_d = rdone_q | (rcnt_q == RST_LAST);
        rcnt_d = rdone_q ? rcnt_q : rcnt_q + RST_W'(1);
        cpu_reset = !rdone_q;
    end
    always_ff @(posedge zclk or negedge reset_n) begin
        if (!reset_n) begin
            rcnt_q <= '0;
            rdone_q <= 1'b0;
            shadow_q <= 1'b0;
            page_q <= PAGE_W'(DEF_PAGE_RST);
        end else begin
            rcnt_q <= rcnt_d;
            rdone_q <= rdone_d;
            shadow_q <= shadow_d;
            page_q <= page_d;
        end
    end
    z80_waitgen #(.FLASH_WS(FLASH_WS)) u_waitgen (
        .zclk(zclk),
        .reset_n(reset_n),
        .hold(cpu_reset),
        .req(romreq),
        .wait_o(wait_w)
    );
endmodule
